// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver: time-multiplexed 7-segment driver for DIGITS BCD digits.
// A prescaler holds each digit enabled for PRESCALE cycles. The shadow register
// is copied to the display register only at a frame boundary, so a frame is
// never torn. seg, dp and an are registered, so they trail the index by one clock.
// Optional feature macro: SEG7_LZB_EN (leading-zero blanking).
//
// Scan sequencing (no enum FSM; the digit index is the state):
//   idx        | meaning
//   0..DIGITS-1| digit currently being scanned
//   wrap       | prescaler at PRESCALE-1; the index advances on this edge
//   boundary   | wrap with idx==DIGITS-1; display <= shadow, frame_tick next cycle
module seg7_mux_driver #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [PS_W-1:0]  LAST_PS  = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]      presc;
    logic [IDX_W-1:0]     idx;
    logic [4*DIGITS-1:0]  shadow_bcd;
    logic [DIGITS-1:0]    shadow_dp;
    logic [4*DIGITS-1:0]  disp_bcd;
    logic [DIGITS-1:0]    disp_dp;

    logic                 wrap;
    logic                 boundary;
    logic [3:0]           cur_bcd;
    logic                 cur_dp;
    logic                 blank;
    logic [6:0]           seg_next;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000001;
        endcase
        return s;
    endfunction

    assign wrap     = (presc == LAST_PS);
    assign boundary = wrap && (idx == LAST_IDX);

    // Prescaler and digit index: index steps once per prescaler wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (wrap) begin
            presc <= '0;
            idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Shadow capture on load; display refresh only at a frame boundary,
    // where a same-edge load bypasses the shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_bcd <= '0;
            shadow_dp  <= '0;
            disp_bcd   <= '0;
            disp_dp    <= '0;
        end else begin
            if (load) begin
                shadow_bcd <= bcd_in;
                shadow_dp  <= dp_in;
            end
            if (boundary) begin
                disp_bcd <= load ? bcd_in : shadow_bcd;
                disp_dp  <= load ? dp_in  : shadow_dp;
            end
        end
    end

    // Select the digit addressed by the current index.
    always_comb begin
        cur_bcd = 4'd0;
        cur_dp  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_bcd = disp_bcd[4*i +: 4];
                cur_dp  = disp_dp[i];
            end
        end
    end

`ifdef SEG7_LZB_EN
    logic [DIGITS-1:0] zero_run;

    // zero_run[i]: digit i and every higher digit hold code 0.
    always_comb begin
        logic z;
        zero_run = '0;
        for (int i = 0; i < DIGITS; i++) begin
            z = 1'b1;
            for (int j = i; j < DIGITS; j++) begin
                if (disp_bcd[4*j +: 4] != 4'd0) z = 1'b0;
            end
            zero_run[i] = z;
        end
    end

    // Digit 0 always shows, so a value of zero still reads "0".
    always_comb begin
        blank = 1'b0;
        for (int i = 1; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) blank = zero_run[i];
        end
    end
`else
    // No blanking: every digit decodes normally.
    always_comb begin
        blank = 1'b0;
    end
`endif

    // Segment pattern for the current digit.
    always_comb begin
        seg_next = blank ? 7'b0000000 : decode(cur_bcd);
    end

    // Registered outputs and the frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= '0;
            dp         <= 1'b0;
            an         <= '0;
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_next;
            dp         <= cur_dp;
            an         <= DIGITS'(1) << idx;
            frame_tick <= boundary;
        end
    end

endmodule

// File: doc/seg7_mux_driver.md
SEG7_MUX_DRIVER -- requirements
Module: seg7_mux_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed BCD digits; legal range 1..8.
REQ-002 SHALL have parameter PRESCALE, default 1000, clock cycles each digit stays enabled; legal range >= 1.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port load, input, 1, samples bcd_in/dp_in into the shadow register.
REQ-006 SHALL have port bcd_in, input, 4*DIGITS, packed BCD; bits [3:0] are digit 0 (least significant).
REQ-007 SHALL have port dp_in, input, DIGITS, decimal point per digit; bit i belongs to digit i.
REQ-008 SHALL have port seg, output, 7, active-high segments {a,b,c,d,e,f,g} = seg[6:0].
REQ-009 SHALL have port dp, output, 1, active-high decimal point of the enabled digit.
REQ-010 SHALL have port an, output, DIGITS, one-hot active-high digit enable.
REQ-011 SHALL have port frame_tick, output, 1, one-cycle pulse at each frame boundary.

Function
REQ-012 Shadow register SHALL capture bcd_in and dp_in on any rising edge with load=1; later loads overwrite earlier ones.
REQ-013 Prescaler SHALL count 0..PRESCALE-1 and wrap; at PRESCALE-1 the digit index SHALL advance, DIGITS-1 wrapping to 0.
REQ-014 Frame boundary SHALL be the edge at which the index wraps DIGITS-1 -> 0; display register SHALL load the shadow value then, including a same-edge load (bcd_in takes precedence).
REQ-015 Display register SHALL NOT change mid-frame; a load between boundaries is shown only from the next frame.
REQ-016 frame_tick SHALL be 1 for exactly the cycle following each frame boundary edge, else 0.
REQ-017 seg, dp, an SHALL be registered and reflect the current index and display register, one clock after an index change.
REQ-018 Encoding {a..g}: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-019 BCD codes 10..15 SHALL display a dash, seg=0000001.
REQ-020 With DIGITS=1 the index SHALL stay 0 and every prescaler wrap SHALL be a frame boundary; with PRESCALE=1 the index SHALL advance every cycle.
REQ-021 Full scan period SHALL be exactly DIGITS*PRESCALE cycles.

Reset
REQ-022 rst_n=0 SHALL immediately, without a clock, clear prescaler, index, shadow, display, seg, dp, an, frame_tick to 0.
REQ-023 First rising edge after rst_n release SHALL give an=1 (digit 0), seg=1111110, dp=0; first frame_tick after DIGITS*PRESCALE cycles.
REQ-024 Reset asserted mid-scan SHALL discard any pending shadow value.

Configuration
REQ-025 Macro SEG7_LZB_EN SHALL enable leading-zero blanking.
REQ-026 When defined: a digit i>0 SHALL show seg=0000000 if it and all higher digits hold 0; dp and an are unaffected; codes 10..15 count as nonzero; digit 0 is never blanked.
REQ-027 When undefined: all digits SHALL decode per REQ-018/REQ-019, zeros shown as 1111110.

Verification (DIGITS=4, PRESCALE=4)
REQ-028 rst_n=0 -> seg=0, dp=0, an=0000, frame_tick=0 without clocking; release -> next edge an=0001, seg=1111110.
REQ-029 load bcd_in=16'h1234 -> after next frame_tick, an 0001/0010/0100/1000 for 4 cycles each, seg 0110011/1111001/1101101/0110000, frame_tick every 16 cycles.
REQ-030 load 16'h1234 then, mid-frame, load 16'h5678 -> current frame still 1234; next frame shows 5678.
REQ-031 load 16'h00A7 -> digit0 1110000, digit1 0000001; digits 3,2 blank 0000000 with SEG7_LZB_EN, 1111110 without.
REQ-032 load 16'h0000, dp_in=4'b0100 -> digit2 dp=1, others dp=0; with SEG7_LZB_EN digits 3..1 blank, digit0 1111110.
REQ-033 rst_n pulsed low mid-scan after load 16'h9999 -> outputs 0 at once; after release digit 0 shows 1111110 (display cleared).
